uart_receive: RTL and testbench
===============================

UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 SHALL have parameter D_WIDTH, default 4, number of data bits per frame, legal range 1..16.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit, even, legal range 2..16.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset, asynchronous, active-high.
REQ-005 SHALL have port rx, input, 1 bit, serial line; idles high; asynchronous to clk.
REQ-006 SHALL have port rx_data, output reg, D_WIDTH bits, last correctly framed data word.
REQ-007 SHALL have port rx_valid, output reg, 1 bit, one-cycle pulse when rx_data is updated.
REQ-008 SHALL have port rx_busy, output reg, 1 bit, high while any state other than IDLE is active.
REQ-009 SHALL have port rx_ferr, output reg, 1 bit, one-cycle pulse on a framing error (stop bit sampled low).
REQ-010 SHALL have port rx_perr, output reg, 1 bit, one-cycle pulse on a parity error.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer, rx_s; all decisions use rx_s only.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK, with a bit-period counter and a bit index.
REQ-013 In IDLE, rx_s=0 SHALL move to START with counter cleared.
REQ-014 In START, when counter = CLKS_PER_BIT/2-1, SHALL sample rx_s: 0 -> DATA with counter and index cleared; 1 -> IDLE (glitch rejected, no pulse).
REQ-015 In DATA, when counter = CLKS_PER_BIT-1, SHALL sample rx_s into the shift register LSB-first, clear the counter and increment the index.
REQ-016 After bit D_WIDTH-1 SHALL go to PARITY if enabled, else STOP.
REQ-017 In STOP, at counter = CLKS_PER_BIT-1: rx_s=1 -> load rx_data, pulse rx_valid, go to IDLE; rx_s=0 -> pulse rx_ferr, leave rx_data unchanged, go to BREAK.
REQ-018 In BREAK SHALL wait for rx_s=1, then go to IDLE; a low line SHALL never restart a frame from BREAK.
REQ-019 rx_valid, rx_ferr and rx_perr SHALL be mutually exclusive and each high for exactly one cycle per frame at most.
REQ-020 rx_data SHALL hold its value between frames; there is no back-pressure and a new frame overwrites it.
REQ-021 A parity error SHALL suppress rx_valid and leave rx_data unchanged; a framing error on the same frame SHALL take priority (rx_ferr only).

Reset
REQ-022 Asserting rst SHALL immediately force IDLE, counter 0, index 0, rx_data 0, rx_valid 0, rx_busy 0, rx_ferr 0, rx_perr 0, synchronizer flops 1.
REQ-023 Reset mid-frame SHALL discard the partial frame with no pulse; reception restarts on the next low line after release.

Configuration
REQ-024 Macro UART_RECEIVE_PARITY_EN defined: SHALL expect one even-parity bit after data, sampled like a data bit; mismatch -> pulse rx_perr at the stop-bit sample point, no rx_valid.
REQ-025 Macro UART_RECEIVE_PARITY_EN undefined: PARITY state SHALL be unreachable, frame = start + D_WIDTH data + stop, rx_perr SHALL be constant 0.

Verification (D_WIDTH=4, CLKS_PER_BIT=4, parity off unless noted)
REQ-026 Frame 0, 0,1,0,1 (LSB-first), 1 -> rx_data=4'hA, rx_valid high for exactly 1 cycle, at the stop-bit sample point plus 1 cycle.
REQ-027 rx low for 1 cycle, then high -> start glitch rejected; no pulse; rx_busy returns to 0 within 4 cycles.
REQ-028 Frame 0xF with stop bit held low for 8 cycles -> rx_ferr pulses once, rx_data unchanged; after rx returns high, next frame 0x3 -> rx_data=4'h3.
REQ-029 rst asserted during data bit 2 -> all outputs 0 in the same cycle, with no rx_valid afterwards; following frame 0x5 received correctly.
REQ-030 Back-to-back frames 0x1 and 0xE, no idle gap -> two rx_valid pulses, rx_data=4'h1 then 4'hE.
REQ-031 With UART_RECEIVE_PARITY_EN, frame 0x7 with parity bit 0 -> rx_perr pulses once and there is no rx_valid; with parity bit 1 -> rx_valid and rx_data=4'h7.

Source files
------------

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - UART frame receiver with synchronizer, framing/break handling
// Optional even-parity bit enabled by defining UART_RECEIVE_PARITY_EN.
module uart_receive #(
  parameter int D_WIDTH      = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               rx_ferr,
  output logic               rx_perr
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t             state, state_n;
  logic               rx_meta, rx_s;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [D_WIDTH-1:0] shift, shift_n;
  logic [D_WIDTH-1:0] data_n;
  logic               valid_n, ferr_n, perr_n, busy_n;
`ifdef UART_RECEIVE_PARITY_EN
  logic               perr_flag, perr_flag_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_busy  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_perr  <= 1'b0;
`ifdef UART_RECEIVE_PARITY_EN
      perr_flag <= 1'b0;
`endif
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      rx_data  <= data_n;
      rx_valid <= valid_n;
      rx_busy  <= busy_n;
      rx_ferr  <= ferr_n;
      rx_perr  <= perr_n;
`ifdef UART_RECEIVE_PARITY_EN
      perr_flag <= perr_flag_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
`ifdef UART_RECEIVE_PARITY_EN
    perr_flag_n = perr_flag;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      // Start bit is re-checked half a bit in; a high line there is a glitch.
      S_START: begin
        if (cnt == HALF_M1) begin
          if (!rx_s) begin
            state_n = S_DATA;
            cnt_n   = '0;
            idx_n   = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          for (int i = 0; i < D_WIDTH; i++) begin
            if (idx == IDX_W'(i)) shift_n[i] = rx_s;
          end
          if (idx == LAST_IDX) begin
            idx_n = '0;
`ifdef UART_RECEIVE_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PARITY: begin
`ifdef UART_RECEIVE_PARITY_EN
        if (cnt == FULL_M1) begin
          cnt_n       = '0;
          perr_flag_n = rx_s ^ (^shift);
          state_n     = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`else
        state_n = S_IDLE;
`endif
      end
      // Framing error outranks parity error; either one leaves rx_data alone.
      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (!rx_s) begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
`ifdef UART_RECEIVE_PARITY_EN
          end else if (perr_flag) begin
            perr_n  = 1'b1;
            state_n = S_IDLE;
`endif
          end else begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_uart_receive.sv
// tb/tb_uart_receive.sv - randomized self-checking bench for uart_receive
module tb_uart_receive;
  localparam int DW  = 4;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_busy, rx_ferr, rx_perr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int obs_kind[$], obs_data[$], obs_cyc[$];
  int exp_kind[$], exp_data[$];
  logic [DW-1:0] model_data = '0;
  logic pv = 1'b0, pf = 1'b0, pp = 1'b0;

  uart_receive #(.D_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_busy(rx_busy), .rx_ferr(rx_ferr), .rx_perr(rx_perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event kinds: 0 = data word, 1 = framing error, 2 = parity error
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid || rx_ferr || rx_perr) begin
        check("exclusive", int'(rx_valid) + int'(rx_ferr) + int'(rx_perr), 1);
        obs_kind.push_back(rx_valid ? 0 : (rx_ferr ? 1 : 2));
        obs_data.push_back(int'(rx_data));
        obs_cyc.push_back(cyc);
      end
      if (rx_valid) check("valid_width", pv, 0);
      if (rx_ferr)  check("ferr_width", pf, 0);
      if (rx_perr)  check("perr_width", pp, 0);
    end
    pv = rx_valid;
    pf = rx_ferr;
    pp = rx_perr;
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input int stop_low, input logic flip);
    last_start = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DW; i++) drive_bit(d[i], CPB);
`ifdef UART_RECEIVE_PARITY_EN
    drive_bit((^d) ^ flip, CPB);
`endif
    if (stop_low > 0) begin
      drive_bit(1'b0, stop_low);
      drive_bit(1'b1, CPB);
      exp_kind.push_back(1);
      exp_data.push_back(0);
    end else begin
      drive_bit(1'b1, CPB);
`ifdef UART_RECEIVE_PARITY_EN
      if (flip) begin
        exp_kind.push_back(2);
        exp_data.push_back(0);
      end else begin
        model_data = d;
        exp_kind.push_back(0);
        exp_data.push_back(int'(d));
      end
`else
      model_data = d;
      exp_kind.push_back(0);
      exp_data.push_back(int'(d));
`endif
    end
  endtask

  task automatic compare_events(input string tag);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check({tag, "_count"}, obs_kind.size(), exp_kind.size());
    for (int i = 0; i < obs_kind.size() && i < exp_kind.size(); i++) begin
      check({tag, "_kind"}, obs_kind[i], exp_kind[i]);
      if (exp_kind[i] == 0) check({tag, "_data"}, obs_data[i], exp_data[i]);
    end
    check({tag, "_rx_data"}, rx_data, model_data);
    obs_kind.delete(); obs_data.delete(); obs_cyc.delete();
    exp_kind.delete(); exp_data.delete();
  endtask

  initial begin
    int exp_cyc;
    rst = 1'b0;
    rx  = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", rx_ferr, 0);
    check("rst_perr", rx_perr, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame and its pulse timing relative to the start edge
    send_frame(4'hA, 0, 1'b0);
    exp_cyc = last_start + 1 + 2 + CPB/2 + (DW + 1) * CPB;
`ifdef UART_RECEIVE_PARITY_EN
    exp_cyc += CPB;
`endif
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("a_events", obs_cyc.size(), 1);
    if (obs_cyc.size() > 0) check("a_valid_cycle", obs_cyc[0], exp_cyc);
    compare_events("frame_a");

    // Start-bit glitch
    drive_bit(1'b0, 1);
    drive_bit(1'b1, CPB + 2);
    check("glitch_busy", rx_busy, 0);
    compare_events("glitch");

    // Framing error, then recovery
    send_frame(4'hF, 8, 1'b0);
    check("ferr_hold", rx_data, 4'hA);
    send_frame(4'h3, 0, 1'b0);
    compare_events("ferr");

    // Reset during data bit 2
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    rx = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_data = '0;
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_valid", rx_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_events("mid_rst");
    send_frame(4'h5, 0, 1'b0);
    compare_events("after_rst");

    // Back-to-back frames
    send_frame(4'h1, 0, 1'b0);
    send_frame(4'hE, 0, 1'b0);
    compare_events("b2b");

`ifdef UART_RECEIVE_PARITY_EN
    send_frame(4'h7, 0, 1'b1);
    compare_events("par_bad");
    send_frame(4'h7, 0, 1'b0);
    compare_events("par_good");
`endif

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        drive_bit(1'b0, $urandom_range(1, CPB/2));
        drive_bit(1'b1, CPB + 2);
      end else if (sel == 1) begin
        send_frame(DW'($urandom), $urandom_range(CPB, 2 * CPB), 1'b0);
      end else begin
        send_frame(DW'($urandom), 0, ($urandom_range(0, 3) == 0));
      end
      drive_bit(1'b1, $urandom_range(0, 5));
      if (n % 8 == 7) compare_events("random");
    end
    compare_events("random_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
